// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit
package ifetch_pkg;
  localparam int ILEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [31:0]     pc;
    logic [ILEN-1:0] instr;
    logic            illegal;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular FIFO with flush, occupancy count and zeroed output when empty
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 32,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign empty_o = r_cnt == '0;
  assign full_o  = r_cnt == FULL;
  assign count_o = r_cnt;
  assign w_pop   = pop_i && !empty_o;
  // a pop frees the slot a same-cycle push into a full FIFO needs
  assign w_push  = push_i && (!full_o || w_pop);
  assign dout_o  = empty_o ? '0 : r_mem[r_rd];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == LAST ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd == LAST ? '0 : r_rd + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk_i)
    if (w_push && !flush_i) r_mem[r_wr] <= din_i;
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction fetch with bounded outstanding requests, in-order buffering
// and discard of responses made stale by a redirect
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_illegal_o,
  input  logic        instr_ready_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  logic [31:0]   r_fetch_pc, w_rsp_pc;
  logic [CW-1:0] r_outstanding, r_discard, w_out_next, w_fifo_count, w_pcq_count;
  logic          w_grant, w_rvalid, w_push, w_pop;
  logic          w_fifo_full, w_fifo_empty, w_pcq_full, w_pcq_empty;
  fetch_entry_t  w_wr_entry, w_head;
  assign imem_req_o  = !rst_i && ({1'b0, r_outstanding} + {1'b0, w_fifo_count} < LIM);
  assign imem_addr_o = r_fetch_pc;
  assign w_grant     = imem_req_o && imem_gnt_i;
  assign w_rvalid    = imem_rvalid_i && r_outstanding != '0;
  assign w_out_next  = r_outstanding + CW'(w_grant) - CW'(w_rvalid);
  assign w_push      = w_rvalid && r_discard == '0 && !redirect_valid_i;
  assign w_pop       = instr_valid_o && instr_ready_i && !redirect_valid_i;
  assign w_wr_entry  = '{pc: w_rsp_pc, instr: imem_rdata_i, illegal: imem_rdata_i[1:0] != 2'b11};
  assign instr_valid_o   = !w_fifo_empty;
  assign instr_o         = w_head.instr;
  assign instr_pc_o      = w_head.pc;
  assign instr_illegal_o = w_head.illegal;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_fetch_pc    <= {BOOT_PC[31:2], 2'b00};
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      r_fetch_pc    <= redirect_valid_i ? (redirect_pc_i & 32'hFFFF_FFFC) :
                       w_grant ? r_fetch_pc + 32'd4 : r_fetch_pc;
      // everything still in flight after this cycle belongs to the old path
      r_discard     <= redirect_valid_i ? w_out_next :
                       (w_rvalid && r_discard != '0) ? r_discard - 1'b1 : r_discard;
    end
  fetch_fifo #(.DEPTH(DEPTH), .W($bits(fetch_entry_t))) u_entries (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_push), .pop_i(w_pop), .flush_i(redirect_valid_i),
    .din_i(w_wr_entry), .dout_o(w_head), .full_o(w_fifo_full), .empty_o(w_fifo_empty),
    .count_o(w_fifo_count)
  );
  // request PCs in grant order; every accepted response retires one, dropped or not
  fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_pcq (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(w_grant), .pop_i(w_rvalid), .flush_i(1'b0),
    .din_i(r_fetch_pc), .dout_o(w_rsp_pc), .full_o(w_pcq_full), .empty_o(w_pcq_empty),
    .count_o(w_pcq_count)
  );
  a_rvalid_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && r_outstanding == '0));
  a_pcq_track: assert property (@(posedge clk_i) disable iff (rst_i)
    w_pcq_count == r_outstanding && !(w_rvalid && w_pcq_empty) && !(w_grant && w_pcq_full && !w_rvalid));
  a_fifo_room: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && w_fifo_full && !w_pop));
endmodule
